// File: rtl/bus_rr_arbiter.sv
// Round-robin arbitrated shared bus with a registered valid/ready output stage.
// A source holding lock can keep the bus for up to BURST_MAX consecutive beats.
// Optional feature macro: BUS_PARITY_EN adds a registered even-parity bit on bus_par_o.
module bus_rr_arbiter #(
  parameter int unsigned NUM_SRC   = 22,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_MAX = 4,
  localparam int unsigned SRC_W    = $clog2(NUM_SRC)
) (
  input  logic                      clock_i,
  input  logic                      clear_i,
  input  logic [NUM_SRC-1:0]        req_i,
  input  logic [NUM_SRC-1:0]        lock_i,
  input  logic [NUM_SRC*DATA_W-1:0] data_in_i,
  output logic [NUM_SRC-1:0]        gnt_o,
  input  logic                      bus_ready_i,
  output logic [DATA_W-1:0]         bus_out_o,
  output logic                      bus_valid_o,
  output logic [SRC_W-1:0]          bus_src_o,
  output logic                      bus_par_o
);

  localparam int unsigned CntW = $clog2(BURST_MAX + 1);

  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [DATA_W-1:0] bus_out_q, bus_out_d;
  logic              bus_valid_q, bus_valid_d;
  logic [SRC_W-1:0]  bus_src_q, bus_src_d;

  logic              slot_free;
  logic              any_req;
  logic              hi_found;
  logic [SRC_W-1:0]  hi_idx, lo_idx, winner;
  logic [DATA_W-1:0] win_data;
  logic [CntW-1:0]   base_cnt;

  assign slot_free = !bus_valid_q || bus_ready_i;

  // Round-robin search: first request at or above rr_ptr, else lowest request overall.
  always_comb begin
    any_req  = 1'b0;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        any_req = 1'b1;
        lo_idx  = SRC_W'(i);
        if (i >= int'(rr_ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = SRC_W'(i);
        end
      end
    end
    winner = hi_found ? hi_idx : lo_idx;
  end

  assign win_data = data_in_i[int'(winner)*DATA_W +: DATA_W];

  // Grant depends only on req, rr_ptr and the output handshake, never on data.
  always_comb begin
    gnt_o = '0;
    if (!clear_i && slot_free && any_req) begin
      gnt_o = NUM_SRC'(1) << winner;
    end
  end

  // Next-state for the output stage, pointer and burst counter.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    bus_out_d   = bus_out_q;
    bus_valid_d = bus_valid_q;
    bus_src_d   = bus_src_q;
    // Count continues only when the locked holder itself wins again.
    base_cnt    = (winner == rr_ptr_q) ? burst_cnt_q : '0;
    if (slot_free) begin
      if (any_req) begin
        bus_out_d   = win_data;
        bus_src_d   = winner;
        bus_valid_d = 1'b1;
        if (lock_i[winner] && (int'(base_cnt) + 1 < int'(BURST_MAX))) begin
          rr_ptr_d    = winner;
          burst_cnt_d = base_cnt + 1'b1;
        end else begin
          rr_ptr_d    = (int'(winner) == int'(NUM_SRC) - 1) ? '0 : winner + 1'b1;
          burst_cnt_d = '0;
        end
      end else begin
        bus_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
      bus_src_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      bus_out_q   <= bus_out_d;
      bus_valid_q <= bus_valid_d;
      bus_src_q   <= bus_src_d;
    end
  end

  assign bus_out_o   = bus_out_q;
  assign bus_valid_o = bus_valid_q;
  assign bus_src_o   = bus_src_q;

`ifdef BUS_PARITY_EN
  logic bus_par_q, bus_par_d;

  // Parity is captured with the beat and frozen alongside bus_out.
  always_comb begin
    bus_par_d = bus_par_q;
    if (slot_free && any_req) begin
      bus_par_d = ^win_data;
    end
  end

  // Parity register with synchronous clear.
  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      bus_par_q <= 1'b0;
    end else begin
      bus_par_q <= bus_par_d;
    end
  end

  assign bus_par_o = bus_par_q;
`else
  assign bus_par_o = 1'b0;
`endif

endmodule
